// File: rtl/shiftsub_div.sv
// Unsigned restoring (shift-subtract) divider: one quotient bit per clock,
// WIDTH CALC cycles per division, single-cycle done pulse with registered results.
module shiftsub_div #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] qw_q, qw_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [2*WIDTH:0] aq_sh_s;
    logic [WIDTH:0]   a_sh_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH:0]   a_new_s;
    logic [WIDTH-1:0] q_new_s;

    // One restoring iteration on the current working registers
    always_comb begin
        aq_sh_s = {a_q, qw_q} << 1;
        a_sh_s  = aq_sh_s[2*WIDTH:WIDTH];
        diff_s  = a_sh_s - {1'b0, m_q};
        if (diff_s[WIDTH] == 1'b1) begin
            a_new_s = a_sh_s;
            q_new_s = {aq_sh_s[WIDTH-1:1], 1'b0};
        end else begin
            a_new_s = diff_s;
            q_new_s = {aq_sh_s[WIDTH-1:1], 1'b1};
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        qw_d        = qw_q;
        m_d         = m_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                if (start == 1'b1) begin
                    if (divisor == {WIDTH{1'b0}}) begin
                        // Zero divisor completes immediately without entering CALC
                        state_d     = DONE;
                        quotient_d  = {WIDTH{1'b1}};
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        state_d = CALC;
                        a_d     = {(WIDTH + 1){1'b0}};
                        qw_d    = dividend;
                        m_d     = divisor;
                        cnt_d   = CW'(WIDTH);
                        dbz_d   = 1'b0;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                a_d   = a_new_s;
                qw_d  = q_new_s;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = DONE;
                    quotient_d  = q_new_s;
                    remainder_d = a_new_s[WIDTH-1:0];
                    done_d      = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= {(WIDTH + 1){1'b0}};
            qw_q        <= {WIDTH{1'b0}};
            m_q         <= {WIDTH{1'b0}};
            cnt_q       <= {CW{1'b0}};
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            qw_q        <= qw_d;
            m_q         <= m_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_shiftsub_div.sv
// Directed-vector bench for shiftsub_div (WIDTH=4) with hand-computed results.
module tb_shiftsub_div;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    int checks   = 0;
    int failures = 0;

    shiftsub_div #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance negedge by negedge until done is seen, bounded
    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 20) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] dd, input logic [3:0] dv,
                          input logic [3:0] qx, input logic [3:0] rx, input logic dbzx);
        int cyc;
        int bcnt;
        int lat;
        lat = (dv == 4'd0) ? 0 : WIDTH;
        @(negedge clk);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(negedge clk);
        start    = 1'b0;
        dividend = ~dd;
        divisor  = ~dv;
        wait_done(cyc, bcnt);
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_busycycles"}, bcnt, lat);
        check({tag, "_q"}, quotient, qx);
        check({tag, "_r"}, remainder, rx);
        check({tag, "_dbz"}, div_by_zero, dbzx);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        @(negedge clk);
        check({tag, "_done_single"}, done, 1'b0);
        check({tag, "_q_hold"}, quotient, qx);
        check({tag, "_r_hold"}, remainder, rx);
    endtask

    initial begin
        int cyc;
        int bcnt;
        int ndone;
        int first_done;
        int second_done;

        rst_n    = 1'b0;
        start    = 1'b1;
        dividend = 4'd5;
        divisor  = 4'd1;
        #1;
        check("rst_q", quotient, 4'd0);
        repeat (3) @(negedge clk);
        check("rst_q_clk", quotient, 4'd0);
        check("rst_r", remainder, 4'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dbz", div_by_zero, 1'b0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_done", done, 1'b0);

        run_op("d13_4", 4'd13, 4'd4, 4'd3, 4'd1, 1'b0);
        run_op("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
        run_op("d3_7", 4'd3, 4'd7, 4'd0, 4'd3, 1'b0);
        run_op("d15_15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0);
        run_op("d0_5", 4'd0, 4'd5, 4'd0, 4'd0, 1'b0);
        run_op("d9_0", 4'd9, 4'd0, 4'd15, 4'd9, 1'b1);
        run_op("d8_2", 4'd8, 4'd2, 4'd4, 4'd0, 1'b0);

        // Start pulsed on the second busy cycle must be ignored
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy1", busy, 1'b1);
        @(negedge clk);
        start = 1'b1; dividend = 4'd6; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bcnt);
        check("ign_latency", cyc, 2);
        check("ign_q", quotient, 4'd3);
        check("ign_r", remainder, 4'd1);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("ign_extra_done", ndone, 0);

        // Reset in the middle of CALC aborts with no done pulse
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_q", quotient, 4'd0);
        check("abort_r", remainder, 4'd0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_dbz", div_by_zero, 1'b0);
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("abort_no_done", ndone, 0);
        rst_n = 1'b1;
        run_op("d10_3", 4'd10, 4'd3, 4'd3, 4'd1, 1'b0);

        // Start held high: back-to-back operations accepted in the DONE cycle
        @(negedge clk);
        start = 1'b1; dividend = 4'd14; divisor = 4'd5;
        first_done  = -1;
        second_done = -1;
        ndone       = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 5) check("b2b_busy_reaccept", busy, 1'b1);
            if (done === 1'b1) begin
                ndone++;
                if (first_done < 0) first_done = k;
                else second_done = k;
                check("b2b_q", quotient, 4'd2);
                check("b2b_r", remainder, 4'd4);
            end
        end
        start = 1'b0;
        check("b2b_ndone", ndone, 2);
        check("b2b_first", first_done, WIDTH);
        check("b2b_period", second_done - first_done, WIDTH + 1);
        repeat (8) @(negedge clk);
        check("b2b_idle_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
